// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG controller blocks.
package ecg_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned BEAT_CNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_DETECT = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/ecg_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th enabled cycle.
module ecg_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // count holds completed cycles, so the current cycle is number count+1;
  // expiry is therefore reported while count==TIMEOUT-1, saturating there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/ecg_stage_sequencer.sv
// Per-sample scheduler: sequences each ADC sample through filter, beat
// detector and output handshake, tracking frame index, beat count and
// sticky overrun/timeout status.
module ecg_stage_sequencer
  import ecg_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 12,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         adc_valid,
  input  logic [SAMPLE_W-1:0]          adc_data,
  output logic                         filt_start,
  output logic [SAMPLE_W-1:0]          filt_data,
  input  logic                         filt_done,
  output logic                         det_start,
  input  logic                         det_done,
  input  logic                         det_beat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_beat,
  output logic [$clog2(FRAME_LEN)-1:0] sample_idx,
  output logic [BEAT_CNT_W-1:0]        beat_count,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         timeout_err,
  output logic [STATE_W-1:0]           state
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_t st;
  logic   busy;
  logic   wd_event;
  logic   wd_expired;

  assign state = st;
  assign busy  = (st == ST_FILTER) || (st == ST_DETECT) || (st == ST_OUTPUT);

  // The awaited event of each busy state; it always causes a state change,
  // so clearing on it (or while not busy) zeroes the count on every entry.
  assign wd_event = ((st == ST_FILTER) && filt_done) ||
                    ((st == ST_DETECT) && det_done)  ||
                    ((st == ST_OUTPUT) && out_ready);

  ecg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy || wd_event),
    .enable  (busy),
    .expired (wd_expired)
  );

  // Sequencer FSM with registered strobes, counters and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      filt_start  <= 1'b0;
      filt_data   <= '0;
      det_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_beat    <= 1'b0;
      sample_idx  <= '0;
      beat_count  <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      filt_start <= 1'b0;
      det_start  <= 1'b0;
      frame_done <= 1'b0;

      if (!en && (st == ST_IDLE || st == ST_ERROR)) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      // a strobe while busy (including the cycle that returns to IDLE) is dropped
      if (adc_valid && st != ST_IDLE) begin
        overrun <= 1'b1;
      end

      case (st)
        ST_IDLE: begin
          if (en && adc_valid) begin
            filt_data  <= adc_data;
            filt_start <= 1'b1;
            st         <= ST_FILTER;
          end
        end
        ST_FILTER: begin
          if (filt_done) begin
            det_start <= 1'b1;
            st        <= ST_DETECT;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            out_valid   <= 1'b0;
            out_beat    <= 1'b0;
            st          <= ST_ERROR;
          end
        end
        ST_DETECT: begin
          if (det_done) begin
            out_beat  <= det_beat;
            out_valid <= 1'b1;
            if (det_beat && beat_count != '1) begin
              beat_count <= beat_count + 1'b1;
            end
            st <= ST_OUTPUT;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            out_valid   <= 1'b0;
            out_beat    <= 1'b0;
            st          <= ST_ERROR;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (sample_idx == IDX_LAST) begin
              sample_idx <= '0;
              frame_done <= 1'b1;
            end else begin
              sample_idx <= sample_idx + 1'b1;
            end
            st <= ST_IDLE;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            out_valid   <= 1'b0;
            out_beat    <= 1'b0;
            st          <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (!en) begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_stage_sequencer.sv
// Scoreboard bench for ecg_stage_sequencer (FRAME_LEN=4, TIMEOUT=8).
module tb_ecg_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        filt_start;
  logic [11:0] filt_data;
  logic        filt_done;
  logic        det_start;
  logic        det_done;
  logic        det_beat;
  logic        out_valid;
  logic        out_ready;
  logic        out_beat;
  logic [1:0]  sample_idx;
  logic [15:0] beat_count;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;
  logic [2:0]  state;

  // responder controls
  logic auto_filt = 1'b1;
  logic man_filt  = 1'b0;
  logic auto_det  = 1'b1;
  logic beat_val  = 1'b0;
  logic ready_lvl = 1'b1;

  assign filt_done = (auto_filt && filt_start) || man_filt;
  assign det_done  = auto_det && det_start;
  assign det_beat  = beat_val;
  assign out_ready = ready_lvl;

  always #5 clk = ~clk;

  ecg_stage_sequencer #(.SAMPLE_W(12), .FRAME_LEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
    .filt_start(filt_start), .filt_data(filt_data), .filt_done(filt_done),
    .det_start(det_start), .det_done(det_done), .det_beat(det_beat),
    .out_valid(out_valid), .out_ready(out_ready), .out_beat(out_beat),
    .sample_idx(sample_idx), .beat_count(beat_count), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err), .state(state)
  );

  typedef struct {
    logic        beat;
    logic [1:0]  idx;
    logic        fd;
    logic [15:0] bcnt;
  } exp_t;

  exp_t        out_q[$];
  logic [11:0] filt_q[$];
  exp_t        mon_e;
  logic [1:0]  exp_idx = '0;
  logic [15:0] exp_bcnt = '0;
  logic        fd_pending = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: filter launches and output handshakes are popped against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (filt_start) begin
        if (filt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL filt_start_unexpected: got pulse with data %0h expected none", filt_data);
        end else begin
          chk("filt_data", 32'(filt_data), 32'(filt_q.pop_front()));
        end
      end
      if (fd_pending || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_pending));
      fd_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got handshake beat %0d expected none", out_beat);
        end else begin
          mon_e = out_q.pop_front();
          chk("out_beat", 32'(out_beat), 32'(mon_e.beat));
          chk("hs_sample_idx", 32'(sample_idx), 32'(mon_e.idx));
          chk("hs_beat_count", 32'(beat_count), 32'(mon_e.bcnt));
          fd_pending = mon_e.fd;
        end
      end
    end
  end

  task automatic expect_sample(input logic [11:0] d, input logic beat);
    exp_t e;
    filt_q.push_back(d);
    if (beat && exp_bcnt != 16'hFFFF) exp_bcnt = exp_bcnt + 16'd1;
    e.beat = beat;
    e.idx  = exp_idx;
    e.fd   = (exp_idx == 2'd3);
    e.bcnt = exp_bcnt;
    out_q.push_back(e);
    exp_idx = exp_idx + 2'd1;
  endtask

  task automatic strobe(input logic [11:0] d);
    @(posedge clk); #1;
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (state == 3'd0) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got state %0d expected return to IDLE within 40 cycles", name, state);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got out_valid 0 expected 1 within 40 cycles", name);
    end
  endtask

  initial begin
    logic [11:0] wrap_data [4];
    logic        wrap_beat [4];
    wrap_data = '{12'h011, 12'h7FF, 12'h800, 12'hFFF};
    wrap_beat = '{1'b0, 1'b1, 1'b0, 1'b1};

    // power-on reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_filt_start", 32'(filt_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_sample_idx", 32'(sample_idx), 32'd0);
    @(negedge clk) rst = 1'b0;

    // asynchronous reset in the middle of FILTER
    auto_filt = 1'b0;
    filt_q.push_back(12'h155);
    strobe(12'h155);
    @(negedge clk);
    chk("midfilter_state", 32'(state), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_filt_data", 32'(filt_data), 32'd0);
    chk("async_rst_det_start", 32'(det_start), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_beat", 32'(out_beat), 32'd0);
    chk("async_rst_flags", 32'({overrun, timeout_err, frame_done}), 32'd0);
    @(negedge clk) rst = 1'b0;
    auto_filt = 1'b1;

    // nominal sample with a beat
    beat_val = 1'b1;
    expect_sample(12'h3A5, 1'b1);
    strobe(12'h3A5);
    chk("filt_start_latency", 32'(filt_start), 32'd1);
    chk("nominal_filt_data", 32'(filt_data), 32'h3A5);
    wait_idle("nominal_idle");
    chk("nominal_sample_idx", 32'(sample_idx), 32'd1);
    chk("nominal_beat_count", 32'(beat_count), 32'd1);

    // frame wrap: the fourth sample of the frame pulses frame_done
    for (int i = 0; i < 4; i++) begin
      beat_val = wrap_beat[i];
      expect_sample(wrap_data[i], wrap_beat[i]);
      strobe(wrap_data[i]);
      wait_idle("wrap_idle");
    end
    chk("wrap_sample_idx", 32'(sample_idx), 32'(exp_idx));
    chk("wrap_beat_count", 32'(beat_count), 32'd3);

    // backpressure with a dropped sample
    ready_lvl = 1'b0;
    beat_val  = 1'b1;
    expect_sample(12'h2C4, 1'b1);
    strobe(12'h2C4);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      adc_valid = (i == 1);
      adc_data  = 12'hBAD;
      if (i == 0) beat_val = 1'b0;
      @(negedge clk);
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_out_beat_hold", 32'(out_beat), 32'd1);
      if (i == 2) chk("bp_overrun", 32'(overrun), 32'd1);
    end
    @(posedge clk); #1;
    adc_valid = 1'b0;
    ready_lvl = 1'b1;
    wait_idle("bp_idle");
    chk("bp_sample_idx", 32'(sample_idx), 32'(exp_idx));
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // watchdog expiry in FILTER
    auto_filt = 1'b0;
    filt_q.push_back(12'h0AA);
    strobe(12'h0AA);
    repeat (7) @(posedge clk);
    #1;
    chk("wd_7th_state", 32'(state), 32'd1);
    chk("wd_7th_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    chk("wd_8th_state", 32'(state), 32'd4);
    chk("wd_8th_err", 32'(timeout_err), 32'd1);
    chk("wd_out_valid", 32'(out_valid), 32'd0);
    chk("wd_idx_kept", 32'(sample_idx), 32'(exp_idx));
    en = 1'b0;
    @(posedge clk); #1;
    chk("err_exit_state", 32'(state), 32'd0);
    chk("err_exit_flag", 32'(timeout_err), 32'd0);
    en = 1'b1;

    // filt_done on the expiry cycle wins
    beat_val = 1'b0;
    expect_sample(12'h5A5, 1'b0);
    strobe(12'h5A5);
    repeat (7) @(posedge clk);
    #1 man_filt = 1'b1;
    @(posedge clk); #1;
    man_filt = 1'b0;
    chk("race_state", 32'(state), 32'd2);
    chk("race_err", 32'(timeout_err), 32'd0);
    auto_filt = 1'b1;
    wait_idle("race_idle");

    // beat counter saturation
    @(negedge clk);
    force dut.beat_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.beat_count;
    exp_bcnt = 16'hFFFE;
    beat_val = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_sample(12'h100 + 12'(i), 1'b1);
      strobe(12'h100 + 12'(i));
      wait_idle("sat_idle");
    end
    chk("sat_beat_count", 32'(beat_count), 32'hFFFF);

    repeat (2) @(negedge clk);
    chk("out_q_drained", 32'(out_q.size()), 32'd0);
    chk("filt_q_drained", 32'(filt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
